// File: rtl/mem_stage_ctrl_pkg.sv
// Shared encodings for the Execute-to-Memory stage: FSM states, load/store
// access types and the store byte-mask / misalignment helpers.
package mem_stage_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACCESS   = 2'd1,
      COMPLETE = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      LD_B  = 3'd0,
      LD_BU = 3'd1,
      LD_H  = 3'd2,
      LD_HU = 3'd3,
      LD_W  = 3'd4
   } ld_type_t;

   typedef enum logic [1:0] {
      ST_B = 2'd0,
      ST_H = 2'd1,
      ST_W = 2'd2
   } st_type_t;

   function automatic logic [3:0] st_mask(input st_type_t st, input logic [1:0] a);
      case (st)
         ST_B:    return 4'b0001 << a;
         ST_H:    return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Halfword ops need addr[0]=0, word ops need addr[1:0]=0; bytes never trap.
   function automatic logic is_misaligned(input logic rd, input ld_type_t lt,
                                          input st_type_t st, input logic [1:0] a);
      logic w_half;
      logic w_word;
      w_half = rd ? (lt == LD_H || lt == LD_HU) : (st == ST_H);
      w_word = rd ? (lt == LD_W) : (st == ST_W);
      return (w_half & a[0]) | (w_word & (a != 2'b00));
   endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/acknowledge bus between the Memory stage and the memory.
interface mem_stage_ctrl_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic          dmem_req;
   logic [AW-1:0] dmem_addr;
   logic [3:0]    dmem_we;
   logic [DW-1:0] dmem_wdata;
   logic          dmem_ack;
   logic [DW-1:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_addr, dmem_we, dmem_wdata,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_addr, dmem_we, dmem_wdata,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/mem_stage_ctrl_load_formatter.sv
// Combinational load-data formatter: selects the byte/half lane (little-endian)
// and sign- or zero-extends to 32 bits. Shared with the writeback path.
module load_formatter
   import mem_stage_ctrl_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  ld_type_t    i_ld_type,
   input  logic [1:0]  i_addr_lo,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      case (i_addr_lo)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_ld_type)
         LD_B:    o_data = {{24{w_byte[7]}}, w_byte};
         LD_BU:   o_data = {24'd0, w_byte};
         LD_H:    o_data = {{16{w_half[15]}}, w_half};
         LD_HU:   o_data = {16'd0, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Execute-to-Memory pipeline register with multi-cycle data-memory handshake.
// Optional macro MEM_MISALIGN_TRAP_EN adds a registered misalign output.
module mem_stage_ctrl
   import mem_stage_ctrl_pkg::*;
#(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          validE,
   input  logic          regWriteE,
   input  logic          memReadE,
   input  logic          memWriteE,
   input  logic [2:0]    ldTypeE,
   input  logic [1:0]    stTypeE,
   input  logic [4:0]    waE,
   input  logic [AW-1:0] aluOutE,
   input  logic [DW-1:0] writeDataE,
   mem_stage_ctrl_if.master dmem,
   output logic [4:0]    waM,
   output logic          regWriteM,
   output logic [DW-1:0] resultM,
   output logic          stall
`ifdef MEM_MISALIGN_TRAP_EN
   ,
   output logic          misalign
`endif
);

   state_t        r_state;
   state_t        w_next;
   logic          r_valid;
   logic          r_reg_write;
   logic          r_mem_read;
   logic          r_mem_write;
   ld_type_t      r_ld_type;
   st_type_t      r_st_type;
   logic [4:0]    r_wa;
   logic [AW-1:0] r_alu_out;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_ld_data;
   logic [31:0]   w_ld_fmt;
   logic          w_capture;
   logic          w_mem_opE;
   logic          w_misE;
   logic          w_trap;

   assign w_capture = (r_state != ACCESS);
   assign w_mem_opE = validE & (memReadE | memWriteE);

`ifdef MEM_MISALIGN_TRAP_EN
   logic r_misalign;
   assign w_misE = w_mem_opE & is_misaligned(memReadE, ld_type_t'(ldTypeE),
                                              st_type_t'(stTypeE), aluOutE[1:0]);
   assign w_trap   = r_misalign;
   assign misalign = r_misalign;
`else
   assign w_misE = 1'b0;
   assign w_trap = 1'b0;
`endif

   load_formatter u_load_formatter (
      .i_rdata   (dmem.dmem_rdata),
      .i_ld_type (r_ld_type),
      .i_addr_lo (r_alu_out[1:0]),
      .o_data    (w_ld_fmt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ACCESS:  if (dmem.dmem_ack) w_next = COMPLETE;
         default: w_next = w_mem_opE ? (w_misE ? COMPLETE : ACCESS) : IDLE;
      endcase
   end

   // Bubbles clear control bits only; data fields load unconditionally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= 1'b0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_ld_type   <= LD_B;
         r_st_type   <= ST_B;
         r_wa        <= '0;
         r_alu_out   <= '0;
         r_wdata     <= '0;
         r_ld_data   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
         r_misalign  <= 1'b0;
`endif
      end else begin
         if (w_capture) begin
            r_valid     <= validE;
            r_reg_write <= validE & regWriteE;
            r_mem_read  <= validE & memReadE;
            r_mem_write <= validE & memWriteE;
            r_ld_type   <= ld_type_t'(ldTypeE);
            r_st_type   <= st_type_t'(stTypeE);
            r_wa        <= waE;
            r_alu_out   <= aluOutE;
            r_wdata     <= writeDataE;
`ifdef MEM_MISALIGN_TRAP_EN
            r_misalign  <= w_misE;
`endif
         end
         if (r_state == ACCESS && dmem.dmem_ack && r_mem_read)
            r_ld_data <= DW'(w_ld_fmt);
      end
   end

   assign dmem.dmem_addr = {r_alu_out[AW-1:2], 2'b00};
   assign waM            = r_wa;
   assign regWriteM      = r_valid & r_reg_write & ~w_trap;

   always_comb begin
      dmem.dmem_req = 1'b0;
      dmem.dmem_we  = '0;
      stall         = 1'b0;
      resultM       = DW'(r_alu_out);
      case (r_st_type)
         ST_B:    dmem.dmem_wdata = {4{r_wdata[7:0]}};
         ST_H:    dmem.dmem_wdata = {2{r_wdata[15:0]}};
         default: dmem.dmem_wdata = r_wdata;
      endcase
      case (r_state)
         ACCESS: begin
            dmem.dmem_req = 1'b1;
            stall         = 1'b1;
            if (r_mem_write) dmem.dmem_we = st_mask(r_st_type, r_alu_out[1:0]);
         end
         COMPLETE: if (r_mem_read) resultM = r_ld_data;
         default: ;
      endcase
   end

endmodule
